// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and MIPS opcode/REGIMM/funct constants for the
//                fetch buffer and its branch pre-decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // One queued fetch: PC, instruction word and fetch address error flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] c_OP_R_TYPE = 6'b000000;
  localparam logic [5:0] c_OP_REGIMM = 6'b000001;
  localparam logic [5:0] c_OP_J      = 6'b000010;
  localparam logic [5:0] c_OP_JAL    = 6'b000011;
  localparam logic [5:0] c_OP_BEQ    = 6'b000100;
  localparam logic [5:0] c_OP_BNE    = 6'b000101;
  localparam logic [5:0] c_OP_BLEZ   = 6'b000110;
  localparam logic [5:0] c_OP_BGTZ   = 6'b000111;

  // REGIMM rt field (instr[20:16])
  localparam logic [4:0] c_RT_BLTZ   = 5'b00000;
  localparam logic [4:0] c_RT_BGEZ   = 5'b00001;
  localparam logic [4:0] c_RT_BLTZAL = 5'b10000;
  localparam logic [4:0] c_RT_BGEZAL = 5'b10001;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] c_FN_JR     = 6'b001000;
  localparam logic [5:0] c_FN_JALR   = 6'b001001;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_predecode.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predecode
//  Description : Combinational pre-decoder flagging branch and jump
//                instructions (those that own a delay slot).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_branch_o
);

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [5:0] w_funct;

  assign w_op    = instr_i[31:26];
  assign w_rt    = instr_i[20:16];
  assign w_funct = instr_i[5:0];

  // Classify the instruction by opcode, then by rt / funct sub-fields.
  always_comb begin
    is_branch_o = 1'b0;
    case (w_op)
      c_OP_BEQ, c_OP_BNE, c_OP_BLEZ, c_OP_BGTZ,
      c_OP_J, c_OP_JAL: is_branch_o = 1'b1;
      c_OP_REGIMM: is_branch_o = (w_rt == c_RT_BLTZ)   || (w_rt == c_RT_BGEZ) ||
                                 (w_rt == c_RT_BLTZAL) || (w_rt == c_RT_BGEZAL);
      c_OP_R_TYPE: is_branch_o = (w_funct == c_FN_JR) || (w_funct == c_FN_JALR);
      default:     is_branch_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Show-ahead instruction queue between fetch and decode with
//                delay-slot tracking and whole-queue flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push_valid,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        push_adel,
  output logic        full,
  input  logic        pop,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        adelD,
  output logic        is_in_delayslotD,
  output logic        empty
);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ds_pending_q, ds_pending_d;

  logic          w_push_acc;
  logic          w_pop_eff;
  logic          w_head_branch;
  fetch_entry_t  w_head;
  fetch_entry_t  w_new;

  // Status comes only from the registered count, so a full queue never
  // accepts a push even when a pop frees a slot in the same cycle.
  assign full       = (count_q == c_DEPTH);
  assign empty      = (count_q == '0);
  assign validD     = ~empty;
  assign w_push_acc = push_valid & ~full;
  assign w_pop_eff  = pop & validD;

  // Show-ahead head; fields read as zero while the queue is empty.
  assign w_head           = mem_q[rd_ptr_q];
  assign instrD           = validD ? w_head.instr : 32'h0;
  assign pcD              = validD ? w_head.pc    : 32'h0;
  assign adelD            = validD & w_head.adel;
  assign is_in_delayslotD = validD & ds_pending_q;

  assign w_new.pc    = push_pc;
  assign w_new.instr = push_instr;
  assign w_new.adel  = push_adel;

  branch_predecode u_predecode (
    .instr_i     (instrD),
    .is_branch_o (w_head_branch)
  );

  // Next-state for pointers, occupancy and the delay-slot marker; flush wins.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    ds_pending_d = ds_pending_q;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      ds_pending_d = 1'b0;
    end else begin
      if (w_push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop_eff) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        ds_pending_d = w_head_branch;
      end
      count_d = count_q + (AW+1)'(w_push_acc) - (AW+1)'(w_pop_eff);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ds_pending_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ds_pending_q <= ds_pending_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (w_push_acc && !flush && !rst) begin
      mem_q[wr_ptr_q] <= w_new;
    end
  end

endmodule
`default_nettype wire
